rtc_multi_ctrl: RTL and testbench

//  Parametrised real-time-clock controller, next generation of the single-channel RTC block.
//  - Free-running timebase.
//  - N_CAP independent event-capture channels, each with arm/valid/overrun status.
//  - N_OUT scheduled pulse-burst outputs (piezo/US drivers) that start on a programmed time match or immediately.
//  - Launch time of each burst is recorded. Sits on the Avalon-MM bus next to the other vidor_sys slaves.

---
 rtl/rtc_pkg.sv | 37 +++
 rtl/rtc_burst_channel.sv | 107 ++++++++++
 rtl/rtc_capture_channel.sv | 75 +++++++
 rtl/rtc_multi_ctrl.sv | 149 ++++++++++++++
 tb/tb_rtc_multi_ctrl.sv | 269 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/rtc_pkg.sv
// Shared definitions for the multi-channel RTC controller: register map,
// control/status bit positions and the burst-channel state encoding.
package rtc_pkg;

    // Register select values (address[15:8])
    localparam logic [7:0] REG_TIME      = 8'h00;
    localparam logic [7:0] REG_CAP_TS    = 8'h01;
    localparam logic [7:0] REG_CAP_CTRL  = 8'h02;
    localparam logic [7:0] REG_OUT_START = 8'h03;
    localparam logic [7:0] REG_OUT_LEN   = 8'h04;
    localparam logic [7:0] REG_OUT_CTRL  = 8'h05;
    localparam logic [7:0] REG_OUT_TS    = 8'h06;

    // CAP_CTRL write bit and read-back status bits
    localparam int CAP_ARM_BIT    = 0;
    localparam int CAP_ST_ARMED   = 0;
    localparam int CAP_ST_VALID   = 1;
    localparam int CAP_ST_OVERRUN = 2;

    // OUT_CTRL write bits and read-back status bits
    localparam int OUT_ARM_BIT    = 0;
    localparam int OUT_START_BIT  = 1;
    localparam int OUT_ABORT_BIT  = 2;
    localparam int OUT_ST_PENDING = 0;
    localparam int OUT_ST_ACTIVE  = 1;

    // Read value for unknown registers or out-of-range channels
    localparam logic [31:0] READ_INVALID = 32'hDEADBEEF;

    // Burst output channel state
    typedef enum logic [1:0] {
        OUT_IDLE    = 2'd0,
        OUT_PENDING = 2'd1,
        OUT_ACTIVE  = 2'd2
    } out_state_e;

endpackage

// File: rtl/rtc_burst_channel.sv
// One scheduled burst output: start/length registers, IDLE/PENDING/ACTIVE
// FSM, length counter latched at launch, launch timestamp.
module rtc_burst_channel
    import rtc_pkg::*;
#(
    parameter int TIME_W    = 32,
    parameter int LEN_RESET = 10000
)(
    input  logic              clock,
    input  logic              reset,
    input  logic [TIME_W-1:0] time_cnt,
    input  logic [TIME_W-1:0] wdata,
    input  logic              start_wr,
    input  logic              len_wr,
    input  logic              ctrl_wr,
    input  logic [2:0]        ctrl_bits,
    output logic [TIME_W-1:0] out_start,
    output logic [TIME_W-1:0] out_len,
    output logic [TIME_W-1:0] out_ts,
    output out_state_e        state_dbg,
    output logic              burst_out
);

    localparam logic [TIME_W-1:0] LEN_INIT = TIME_W'(LEN_RESET);
    localparam logic [TIME_W-1:0] ONE      = TIME_W'(1);

    out_state_e        state_q;
    out_state_e        state_n;
    logic              launch;
    logic              do_arm;
    logic              do_start;
    logic              do_abort;
    logic [TIME_W-1:0] start_q;
    logic [TIME_W-1:0] len_q;
    logic [TIME_W-1:0] ts_q;
    logic [TIME_W-1:0] cnt_q;
    logic              burst_q;

    assign do_arm   = ctrl_wr & ctrl_bits[OUT_ARM_BIT];
    assign do_start = ctrl_wr & ctrl_bits[OUT_START_BIT];
    assign do_abort = ctrl_wr & ctrl_bits[OUT_ABORT_BIT];

    // State register
    always_ff @(posedge clock or posedge reset) begin
        if (reset) state_q <= OUT_IDLE;
        else       state_q <= state_n;
    end

    // Next state; abort overrides everything, a zero-length launch falls back to IDLE.
    always_comb begin
        state_n = state_q;
        launch  = 1'b0;
        if (do_abort) begin
            state_n = OUT_IDLE;
        end else begin
            case (state_q)
                OUT_IDLE: begin
                    if (do_start)    launch  = 1'b1;
                    else if (do_arm) state_n = OUT_PENDING;
                end
                OUT_PENDING: begin
                    if (do_start || time_cnt == start_q) launch = 1'b1;
                end
                OUT_ACTIVE: begin
                    if (cnt_q == ONE) state_n = OUT_IDLE;
                end
                default: state_n = OUT_IDLE;
            endcase
            if (launch) state_n = (len_q == '0) ? OUT_IDLE : OUT_ACTIVE;
        end
    end

    // Length counter, launch timestamp and registered burst output.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            ts_q    <= '0;
            burst_q <= 1'b0;
        end else begin
            burst_q <= (state_n == OUT_ACTIVE);
            if (launch && len_q != '0) begin
                cnt_q <= len_q;
                ts_q  <= time_cnt;
            end else if (state_q == OUT_ACTIVE) begin
                cnt_q <= cnt_q - ONE;
            end
        end
    end

    // Programmable start time and length; the running burst uses the latched count.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            start_q <= '0;
            len_q   <= LEN_INIT;
        end else begin
            if (start_wr) start_q <= wdata;
            if (len_wr)   len_q   <= wdata;
        end
    end

    assign out_start = start_q;
    assign out_len   = len_q;
    assign out_ts    = ts_q;
    assign state_dbg = state_q;
    assign burst_out = burst_q;

endmodule

// File: rtl/rtc_capture_channel.sv
// One event-capture channel: input synchroniser, registered rising-edge
// detect, latency-compensated timestamp and arm/valid/overrun status.
module rtc_capture_channel
    import rtc_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int SYNC_STAGES = 2
)(
    input  logic              clock,
    input  logic              reset,
    input  logic              event_in,
    input  logic              arm_wr,
    input  logic [TIME_W-1:0] time_cnt,
    output logic [TIME_W-1:0] cap_ts,
    output logic [2:0]        cap_status
);

    // Cycles from the event being first sampled to edge_q being used:
    // the synchroniser stages plus the registered edge flag.
    localparam logic [TIME_W-1:0] LATENCY = TIME_W'(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic                   edge_q;
    logic                   armed_q;
    logic                   valid_q;
    logic                   overrun_q;
    logic [TIME_W-1:0]      ts_q;

    // Synchronise the asynchronous input and register a one-cycle rising-edge flag.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            prev_q <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], event_in};
            prev_q <= sync_q[SYNC_STAGES-1];
            edge_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
        end
    end

    // Timestamp and status; an arm write in the same cycle as an edge wins.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            armed_q   <= 1'b0;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
            ts_q      <= '0;
        end else if (arm_wr) begin
            armed_q   <= 1'b1;
            valid_q   <= 1'b0;
            overrun_q <= 1'b0;
        end else if (edge_q) begin
            if (armed_q) begin
                ts_q    <= time_cnt - LATENCY;
                valid_q <= 1'b1;
                armed_q <= 1'b0;
            end else if (valid_q) begin
                overrun_q <= 1'b1;
            end
        end
    end

    assign cap_ts = ts_q;

    // Status packing for the CAP_CTRL read-back
    always_comb begin
        cap_status                 = '0;
        cap_status[CAP_ST_ARMED]   = armed_q;
        cap_status[CAP_ST_VALID]   = valid_q;
        cap_status[CAP_ST_OVERRUN] = overrun_q;
    end

endmodule

// File: rtl/rtc_multi_ctrl.sv
// Multi-channel RTC controller: free-running timebase, Avalon-MM register
// decode and read mux around the capture and burst channel arrays.
//
// Avalon handshake: a read is requested while read=1. In its first cycle
// waitrequest=1 and readdata is loaded at the closing edge; in the next
// cycle waitrequest=0 and the master takes readdata. Writes never stall
// and act at the edge that samples write=1.
module rtc_multi_ctrl
    import rtc_pkg::*;
#(
    parameter int TIME_W      = 32,
    parameter int N_CAP       = 2,
    parameter int N_OUT       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int LEN_RESET   = 10000
)(
    input  logic             clock,
    input  logic             reset,
    input  logic [N_CAP-1:0] event_in,
    input  logic [15:0]      avalon_slave_address,
    input  logic             avalon_slave_write,
    input  logic [31:0]      avalon_slave_writedata,
    input  logic             avalon_slave_read,
    output logic [31:0]      avalon_slave_readdata,
    output logic             avalon_slave_waitrequest,
    output logic [N_OUT-1:0] burst_out
);

    logic [7:0]        sel;
    logic [7:0]        ch;
    logic [TIME_W-1:0] wdata;
    logic [TIME_W-1:0] time_cnt;
    logic              time_wr;
    logic              rd_first;
    logic              rd_pend_q;
    logic [31:0]       rd_mux;

    logic [TIME_W-1:0] cap_ts     [N_CAP];
    logic [2:0]        cap_status [N_CAP];
    logic [TIME_W-1:0] out_start  [N_OUT];
    logic [TIME_W-1:0] out_len    [N_OUT];
    logic [TIME_W-1:0] out_ts     [N_OUT];
    out_state_e        out_state  [N_OUT];

    assign sel     = avalon_slave_address[15:8];
    assign ch      = avalon_slave_address[7:0];
    assign wdata   = avalon_slave_writedata[TIME_W-1:0];
    assign time_wr = avalon_slave_write && sel == REG_TIME;

    // Timebase: counts every cycle and wraps; a TIME write reloads it.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)        time_cnt <= '0;
        else if (time_wr) time_cnt <= wdata;
        else              time_cnt <= time_cnt + TIME_W'(1);
    end

    genvar g;
    generate
        for (g = 0; g < N_CAP; g++) begin : g_cap
            rtc_capture_channel #(
                .TIME_W      (TIME_W),
                .SYNC_STAGES (SYNC_STAGES)
            ) u_cap (
                .clock      (clock),
                .reset      (reset),
                .event_in   (event_in[g]),
                .arm_wr     (avalon_slave_write && sel == REG_CAP_CTRL && ch == 8'(g)
                             && avalon_slave_writedata[CAP_ARM_BIT]),
                .time_cnt   (time_cnt),
                .cap_ts     (cap_ts[g]),
                .cap_status (cap_status[g])
            );
        end

        for (g = 0; g < N_OUT; g++) begin : g_out
            rtc_burst_channel #(
                .TIME_W    (TIME_W),
                .LEN_RESET (LEN_RESET)
            ) u_out (
                .clock     (clock),
                .reset     (reset),
                .time_cnt  (time_cnt),
                .wdata     (wdata),
                .start_wr  (avalon_slave_write && sel == REG_OUT_START && ch == 8'(g)),
                .len_wr    (avalon_slave_write && sel == REG_OUT_LEN && ch == 8'(g)),
                .ctrl_wr   (avalon_slave_write && sel == REG_OUT_CTRL && ch == 8'(g)),
                .ctrl_bits (avalon_slave_writedata[2:0]),
                .out_start (out_start[g]),
                .out_len   (out_len[g]),
                .out_ts    (out_ts[g]),
                .state_dbg (out_state[g]),
                .burst_out (burst_out[g])
            );
        end
    endgenerate

    // Read mux; anything not matched (bad select or channel) reads READ_INVALID.
    always_comb begin
        rd_mux = READ_INVALID;
        case (sel)
            REG_TIME: rd_mux = 32'(time_cnt);
            REG_CAP_TS: begin
                for (int i = 0; i < N_CAP; i++)
                    if (ch == 8'(i)) rd_mux = 32'(cap_ts[i]);
            end
            REG_CAP_CTRL: begin
                for (int i = 0; i < N_CAP; i++)
                    if (ch == 8'(i)) rd_mux = 32'(cap_status[i]);
            end
            REG_OUT_START: begin
                for (int i = 0; i < N_OUT; i++)
                    if (ch == 8'(i)) rd_mux = 32'(out_start[i]);
            end
            REG_OUT_LEN: begin
                for (int i = 0; i < N_OUT; i++)
                    if (ch == 8'(i)) rd_mux = 32'(out_len[i]);
            end
            REG_OUT_CTRL: begin
                for (int i = 0; i < N_OUT; i++) begin
                    if (ch == 8'(i)) begin
                        rd_mux                 = '0;
                        rd_mux[OUT_ST_PENDING] = (out_state[i] == OUT_PENDING);
                        rd_mux[OUT_ST_ACTIVE]  = (out_state[i] == OUT_ACTIVE);
                    end
                end
            end
            REG_OUT_TS: begin
                for (int i = 0; i < N_OUT; i++)
                    if (ch == 8'(i)) rd_mux = 32'(out_ts[i]);
            end
            default: rd_mux = READ_INVALID;
        endcase
    end

    assign rd_first                 = avalon_slave_read & ~rd_pend_q;
    assign avalon_slave_waitrequest = rd_first;

    // Read pipeline: stall the first cycle, present registered data the next.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_pend_q             <= 1'b0;
            avalon_slave_readdata <= '0;
        end else begin
            rd_pend_q <= rd_first;
            if (rd_first) avalon_slave_readdata <= rd_mux;
        end
    end

endmodule

// File: tb/tb_rtc_multi_ctrl.sv
// Directed bench for rtc_multi_ctrl: register table plus hand-written
// sequences for timebase wrap, capture, scheduled/immediate bursts and reset.
module tb_rtc_multi_ctrl;

    logic        clock;
    logic        reset;
    logic [1:0]  event_in;
    logic [15:0] avalon_slave_address;
    logic        avalon_slave_write;
    logic [31:0] avalon_slave_writedata;
    logic        avalon_slave_read;
    logic [31:0] avalon_slave_readdata;
    logic        avalon_slave_waitrequest;
    logic [1:0]  burst_out;

    int checks = 0;
    int errors = 0;

    // Reference timebase: value of the DUT time counter in the current cycle
    logic [31:0] model_t;

    rtc_multi_ctrl dut (
        .clock                    (clock),
        .reset                    (reset),
        .event_in                 (event_in),
        .avalon_slave_address     (avalon_slave_address),
        .avalon_slave_write       (avalon_slave_write),
        .avalon_slave_writedata   (avalon_slave_writedata),
        .avalon_slave_read        (avalon_slave_read),
        .avalon_slave_readdata    (avalon_slave_readdata),
        .avalon_slave_waitrequest (avalon_slave_waitrequest),
        .burst_out                (burst_out)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock or posedge reset) begin
        if (reset)
            model_t <= 32'h0;
        else if (avalon_slave_write && avalon_slave_address[15:8] == 8'h00)
            model_t <= avalon_slave_writedata;
        else
            model_t <= model_t + 32'h1;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- scoreboard helpers ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // ---------------- driver tasks (called and returning at a negedge) ----------------
    task automatic bus_write(input logic [15:0] addr, input logic [31:0] data);
        avalon_slave_address   = addr;
        avalon_slave_writedata = data;
        avalon_slave_write     = 1'b1;
        @(negedge clock);
        avalon_slave_write     = 1'b0;
    endtask

    task automatic bus_read(input logic [15:0] addr, output logic [31:0] data, output int waits);
        bit done;
        done  = 1'b0;
        waits = 0;
        data  = '0;
        avalon_slave_address = addr;
        avalon_slave_read    = 1'b1;
        for (int k = 0; k < 4 && !done; k++) begin
            #1;
            if (avalon_slave_waitrequest) begin
                waits++;
                @(negedge clock);
            end else begin
                data = avalon_slave_readdata;
                done = 1'b1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL read_timeout actual=stalled required=data addr=%h", addr);
        end
        @(negedge clock);
        avalon_slave_read = 1'b0;
    endtask

    task automatic rd_check(input string name, input logic [15:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        int w;
        bus_read(addr, d, w);
        check(name, d, exp);
        check({name, "_wait"}, 32'(w), 32'd1);
    endtask

    // ---------------- register vector table ----------------
    typedef struct {
        logic        do_wr;
        logic [15:0] waddr;
        logic [31:0] wdata;
        logic [15:0] raddr;
        logic [31:0] exp;
    } vec_t;

    vec_t vecs[13];

    task automatic apply_vecs(input int lo, input int hi);
        for (int i = lo; i <= hi; i++) begin
            if (vecs[i].do_wr) bus_write(vecs[i].waddr, vecs[i].wdata);
            rd_check($sformatf("vec%0d", i), vecs[i].raddr, vecs[i].exp);
        end
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic [31:0] t_ev;
        logic [31:0] t0;
        logic [31:0] first;
        logic [31:0] last;
        int          hi;

        // Rows 0..6 are reset values and are reused after the mid-burst reset.
        vecs[0]  = '{1'b0, 16'h0000, 32'h0,    16'h0100, 32'h0};         // CAP_TS ch0
        vecs[1]  = '{1'b0, 16'h0000, 32'h0,    16'h0201, 32'h0};         // CAP_CTRL ch1
        vecs[2]  = '{1'b0, 16'h0000, 32'h0,    16'h0301, 32'h0};         // OUT_START ch1
        vecs[3]  = '{1'b0, 16'h0000, 32'h0,    16'h0400, 32'd10000};     // OUT_LEN ch0
        vecs[4]  = '{1'b0, 16'h0000, 32'h0,    16'h0401, 32'd10000};     // OUT_LEN ch1
        vecs[5]  = '{1'b0, 16'h0000, 32'h0,    16'h0501, 32'h0};         // OUT_CTRL ch1
        vecs[6]  = '{1'b0, 16'h0000, 32'h0,    16'h0600, 32'h0};         // OUT_TS ch0
        vecs[7]  = '{1'b1, 16'h0301, 32'h1234, 16'h0301, 32'h1234};      // OUT_START ch1 r/w
        vecs[8]  = '{1'b1, 16'h0401, 32'd77,   16'h0401, 32'd77};        // OUT_LEN ch1 r/w
        vecs[9]  = '{1'b0, 16'h0000, 32'h0,    16'h0102, 32'hDEADBEEF};  // CAP_TS ch=N_CAP
        vecs[10] = '{1'b0, 16'h0000, 32'h0,    16'h0700, 32'hDEADBEEF};  // unknown select
        vecs[11] = '{1'b0, 16'h0000, 32'h0,    16'h0402, 32'hDEADBEEF};  // OUT_LEN ch=N_OUT
        vecs[12] = '{1'b1, 16'h0402, 32'd5,    16'h0400, 32'd10000};     // ignored write

        reset                  = 1'b1;
        event_in               = 2'b00;
        avalon_slave_address   = 16'h0;
        avalon_slave_write     = 1'b0;
        avalon_slave_writedata = 32'h0;
        avalon_slave_read      = 1'b0;
        #1;
        check("reset_burst", 32'(burst_out), 32'h0);
        check("reset_readdata", avalon_slave_readdata, 32'h0);
        repeat (3) @(negedge clock);
        reset = 1'b0;

        // Reset values, register r/w, invalid addresses
        rd_check("time_after_reset", 16'h0000, model_t);
        apply_vecs(0, 12);

        // Timebase wrap
        bus_write(16'h0000, 32'hFFFFFFFD);
        repeat (3) @(negedge clock);
        rd_check("time_wrap", 16'h0000, 32'h0);
        rd_check("time_wrap_next", 16'h0000, 32'h2);

        // Capture channel 1: arm, event, overrun
        bus_write(16'h0201, 32'h1);
        rd_check("cap1_armed", 16'h0201, 32'h1);
        t_ev = model_t;
        event_in[1] = 1'b1;
        repeat (3) @(negedge clock);
        event_in[1] = 1'b0;
        repeat (5) @(negedge clock);
        rd_check("cap1_ts", 16'h0101, t_ev);
        rd_check("cap1_valid", 16'h0201, 32'h2);
        event_in[1] = 1'b1;
        repeat (3) @(negedge clock);
        event_in[1] = 1'b0;
        repeat (5) @(negedge clock);
        rd_check("cap1_overrun", 16'h0201, 32'h6);
        rd_check("cap1_ts_kept", 16'h0101, t_ev);
        rd_check("cap0_untouched", 16'h0200, 32'h0);
        bus_write(16'h0201, 32'h1);
        rd_check("cap1_rearm", 16'h0201, 32'h1);
        rd_check("time_track", 16'h0000, model_t);

        // Scheduled burst on channel 0
        bus_write(16'h0300, 32'd1000);
        bus_write(16'h0400, 32'd5);
        bus_write(16'h0000, 32'd990);
        bus_write(16'h0500, 32'h1);
        rd_check("out0_pending", 16'h0500, 32'h1);
        first = 32'h0;
        last  = 32'h0;
        hi    = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clock);
            if (burst_out[0]) begin
                if (hi == 0) first = model_t;
                last = model_t;
                hi++;
            end
        end
        check("out0_first", first, 32'd1001);
        check("out0_last", last, 32'd1005);
        check("out0_count", 32'(hi), 32'd5);
        rd_check("out0_ts", 16'h0600, 32'd1000);
        rd_check("out0_idle", 16'h0500, 32'h0);

        // Zero length: no pulse, timestamp kept
        bus_write(16'h0400, 32'd0);
        bus_write(16'h0500, 32'h2);
        hi = 0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clock);
            if (burst_out[0]) hi++;
        end
        check("len0_no_pulse", 32'(hi), 32'd0);
        rd_check("len0_idle", 16'h0500, 32'h0);
        rd_check("len0_ts_kept", 16'h0600, 32'd1000);

        // Immediate burst on channel 1, length change mid-burst, abort
        bus_write(16'h0401, 32'd10000);
        t0 = model_t;
        bus_write(16'h0501, 32'h2);
        check("out1_rise", 32'(burst_out[1]), 32'h1);
        bus_write(16'h0401, 32'd3);
        rd_check("out1_active", 16'h0501, 32'h2);
        hi = 0;
        for (int k = 0; k < 45; k++) begin
            @(negedge clock);
            if (!burst_out[1]) hi++;
        end
        check("out1_held_high", 32'(hi), 32'd0);
        bus_write(16'h0501, 32'h4);
        check("out1_abort_low", 32'(burst_out[1]), 32'h0);
        rd_check("out1_abort_idle", 16'h0501, 32'h0);
        rd_check("out1_ts", 16'h0601, t0);
        rd_check("out1_len_new", 16'h0401, 32'd3);

        // Abort beats start in the same write
        bus_write(16'h0501, 32'h6);
        check("abort_wins_low", 32'(burst_out[1]), 32'h0);
        rd_check("abort_wins_idle", 16'h0501, 32'h0);

        // Reset in the middle of a burst
        bus_write(16'h0400, 32'd100);
        bus_write(16'h0500, 32'h2);
        repeat (3) @(negedge clock);
        check("pre_reset_burst", 32'(burst_out[0]), 32'h1);
        reset = 1'b1;
        #1;
        check("async_reset_burst", 32'(burst_out), 32'h0);
        check("async_reset_readdata", avalon_slave_readdata, 32'h0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        rd_check("time_after_reset2", 16'h0000, model_t);
        apply_vecs(0, 6);
        check("burst_after_reset", 32'(burst_out), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
